// File: rtl/y_signature_collector.sv
// y_signature_collector
// Compresses a run of y samples into a MISR signature and compares the final
// value with a golden signature. One sample is absorbed per clock with y_valid.
module y_signature_collector #(
   parameter int          DATA_W = 192,
   parameter int          SIG_W  = 32,
   parameter logic [31:0] POLY   = 32'h04C11DB7,
   parameter logic [31:0] SEED   = 32'hFFFFFFFF,
   parameter int          CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_samples,
   input  logic [DATA_W-1:0] y,
   input  logic              y_valid,
   input  logic [SIG_W-1:0]  expected_sig,
   output logic              busy,
   output logic              done,
   output logic [SIG_W-1:0]  signature,
   output logic [CNT_W-1:0]  sample_count,
   output logic              match
);

   localparam int NSLICE = DATA_W / SIG_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [SIG_W-1:0]  sig_q, sig_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic              match_q, match_d;

   logic [SIG_W-1:0]  fold;
   logic [SIG_W-1:0]  step_sig;
   logic [CNT_W-1:0]  cnt_inc;
   logic              start_ok;
   logic              absorb;
   logic              last_sample;

   // Chained XOR of the SIG_W-wide slices of y; slice_x[k] holds the fold of
   // the first k slices.
   logic [SIG_W-1:0]  slice_x [0:NSLICE];

   assign slice_x[0] = '0;

   generate
      for (genvar gi = 0; gi < NSLICE; gi++) begin : g_fold
         assign slice_x[gi+1] = slice_x[gi] ^ y[gi*SIG_W +: SIG_W];
      end
   endgenerate

   assign fold        = slice_x[NSLICE];
   assign step_sig    = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? SIG_W'(POLY) : '0) ^ fold;
   assign cnt_inc     = cnt_q + CNT_W'(1);
   // start is only honoured outside RUN.
   assign start_ok    = start && (state_q != S_RUN);
   assign absorb      = (state_q == S_RUN) && y_valid;
   assign last_sample = absorb && (cnt_inc == n_q);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = (num_samples != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            if (last_sample) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values: load on start, MISR step on each absorbed sample;
   // match is evaluated against the signature being written on the DONE entry edge.
   always_comb begin
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      match_d = match_q;
      if (start_ok) begin
         sig_d   = SIG_W'(SEED);
         cnt_d   = '0;
         n_d     = num_samples;
         match_d = (num_samples == '0) ? (SIG_W'(SEED) == expected_sig) : 1'b0;
      end else if (absorb) begin
         sig_d = step_sig;
         cnt_d = cnt_inc;
         if (last_sample) begin
            match_d = (step_sig == expected_sig);
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q   <= SIG_W'(SEED);
         cnt_q   <= '0;
         n_q     <= '0;
         match_q <= 1'b0;
      end else begin
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
         match_q <= match_d;
      end
   end

   // Output decode
   always_comb begin
      busy         = (state_q == S_RUN);
      done         = (state_q == S_DONE);
      signature    = sig_q;
      sample_count = cnt_q;
      match        = match_q;
   end

endmodule

// File: tb/tb_y_signature_collector.sv
// Testbench for y_signature_collector: directed cases plus randomized runs
// checked against a queue-based signature model.
module tb_y_signature_collector;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [7:0]    num_samples;
   logic [191:0]  y;
   logic          y_valid;
   logic [31:0]   expected_sig;
   logic          busy;
   logic          done;
   logic [31:0]   signature;
   logic [7:0]    sample_count;
   logic          match;

   int n_checks = 0;
   int n_fail   = 0;

   logic [191:0] samp_q [$];
   bit           pat_q  [$];

   always #5 clk = ~clk;

   y_signature_collector dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .num_samples  (num_samples),
      .y            (y),
      .y_valid      (y_valid),
      .expected_sig (expected_sig),
      .busy         (busy),
      .done         (done),
      .signature    (signature),
      .sample_count (sample_count),
      .match        (match)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [191:0] rand192();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Signature of the whole sample queue: seed, then one MISR step per sample.
   function automatic logic [31:0] model_sig();
      logic [31:0]  s;
      logic [31:0]  f;
      logic [191:0] v;
      s = 32'hFFFFFFFF;
      foreach (samp_q[i]) begin
         v = samp_q[i];
         f = 32'h0;
         for (int k = 0; k < 6; k++) f = f ^ 32'(v >> (32 * k));
         s = (s << 1) ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
      end
      return s;
   endfunction

   // One run of samp_q.size() samples; good selects a matching golden value.
   task automatic run_case(input string tag, input bit good);
      logic [31:0] model;
      int          n;
      int          idx;
      int          cyc;
      bit          v;
      n     = samp_q.size();
      model = model_sig();
      expected_sig = good ? model : (model ^ 32'h0000_0100);
      start       = 1'b1;
      num_samples = 8'(n);
      y_valid     = 1'(($urandom));
      y           = rand192();
      tick();
      start = 1'b0;
      check({tag, ".start_busy"}, 64'(busy), 64'(n != 0));
      check({tag, ".start_done"}, 64'(done), 64'(n == 0));
      check({tag, ".start_cnt"}, 64'(sample_count), 64'd0);
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 4000) begin
         if (pat_q.size() > 0) v = pat_q.pop_front();
         else v = ($urandom_range(0, 99) < 70);
         y_valid     = v;
         y           = v ? samp_q[idx] : rand192();
         start       = ($urandom_range(0, 3) == 0);
         num_samples = 8'($urandom);
         tick();
         cyc++;
         if (v) idx++;
         check({tag, ".cnt"}, 64'(sample_count), 64'(idx));
         check({tag, ".done"}, 64'(done), 64'(idx == n));
         check({tag, ".busy"}, 64'(busy), 64'(idx != n));
      end
      if (idx < n) check({tag, ".timeout"}, 64'(idx), 64'(n));
      start   = 1'b0;
      y_valid = 1'b0;
      check({tag, ".sig"}, 64'(signature), 64'(model));
      check({tag, ".match"}, 64'(match), 64'(good));
      // y is ignored in DONE
      y_valid = 1'b1;
      y       = rand192();
      tick();
      y_valid = 1'b0;
      check({tag, ".hold_sig"}, 64'(signature), 64'(model));
      check({tag, ".hold_done"}, 64'(done), 64'd1);
      check({tag, ".hold_cnt"}, 64'(sample_count), 64'(n));
      $display("run %s: N=%0d sig=%08h match=%0d", tag, n, signature, match);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; num_samples = '0; y = '0; y_valid = 1'b0;
      expected_sig = '0;

      // 1: reset state
      tick(); tick();
      check("rst.busy", 64'(busy), 64'd0);
      check("rst.done", 64'(done), 64'd0);
      check("rst.match", 64'(match), 64'd0);
      check("rst.sig", 64'(signature), 64'hFFFFFFFF);
      check("rst.cnt", 64'(sample_count), 64'd0);
      rst = 1'b0;
      tick();

      // 2: single zero sample
      samp_q = '{192'h0};
      run_case("zero", 1'b1);
      check("zero.lit", 64'(signature), 64'hFB3EE249);

      // 3: all-ones folds to zero, then restart from DONE with y=1
      samp_q = '{{192{1'b1}}};
      run_case("ones", 1'b1);
      check("ones.lit", 64'(signature), 64'hFB3EE249);
      samp_q = '{192'h1};
      run_case("one", 1'b1);
      check("one.lit", 64'(signature), 64'hFB3EE248);

      // 4: gapped valid pattern with wrong golden value
      samp_q = '{rand192(), rand192(), rand192()};
      pat_q  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      run_case("gap", 1'b0);

      // 5: zero-length run
      samp_q = {};
      run_case("empty", 1'b1);
      check("empty.lit", 64'(signature), 64'hFFFFFFFF);

      // 6: reset in the middle of a run
      samp_q = '{192'h0};
      start = 1'b1; num_samples = 8'd5; tick(); start = 1'b0;
      y_valid = 1'b1; y = rand192(); tick(); y = rand192(); tick();
      check("mid.cnt2", 64'(sample_count), 64'd2);
      y_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
      check("mid.busy", 64'(busy), 64'd0);
      check("mid.done", 64'(done), 64'd0);
      check("mid.sig", 64'(signature), 64'hFFFFFFFF);
      check("mid.cnt", 64'(sample_count), 64'd0);
      run_case("after_rst", 1'b1);
      check("after_rst.lit", 64'(signature), 64'hFB3EE249);

      // rst and start together: rst wins
      rst = 1'b1; start = 1'b1; num_samples = 8'd4; tick();
      rst = 1'b0; start = 1'b0;
      check("rst_start.busy", 64'(busy), 64'd0);
      check("rst_start.done", 64'(done), 64'd0);

      // randomized runs
      for (int r = 0; r < 25; r++) begin
         int n;
         n = $urandom_range(0, 12);
         samp_q = {};
         for (int i = 0; i < n; i++) samp_q.push_back(rand192());
         run_case($sformatf("rand%0d", r), bit'($urandom));
      end

      // maximum-length run
      samp_q = {};
      for (int i = 0; i < 255; i++) samp_q.push_back(rand192());
      run_case("max", 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
